// File: rtl/tile_spawner.sv
// tile_spawner: places one new tile on a 4x4 board of CELL_W-bit tile exponents.
// On a request it latches the board, a random start cell and the 2-vs-4 choice.
// It then probes one cell per clock, wrapping from 15 to 0, until it finds an empty cell.
// If all 16 cells are occupied it reports a full board and places nothing.
// Optional build macro TILE_SPAWN_DUAL_START_EN: the first request after reset
// places two tiles, which is the standard opening position.
module tile_spawner #(
    parameter int CELL_W  = 4,
    parameter int N_CELLS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spawn_req_i,
    input  logic [N_CELLS*CELL_W-1:0] board_in_i,
    input  logic [3:0]                rand_i,
    input  logic                      two_or_four_i,
    output logic [N_CELLS*CELL_W-1:0] board_out_o,
    output logic                      spawn_done_o,
    output logic                      spawn_ok_o,
    output logic [3:0]                spawn_idx_o,
    output logic                      busy_o
);

    localparam int BOARD_W = N_CELLS * CELL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
`ifdef TILE_SPAWN_DUAL_START_EN
        , S_RESTART
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [BOARD_W-1:0]   board_out_q, board_out_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           probes_q, probes_d;
    logic [3:0]           spawn_idx_q, spawn_idx_d;
    logic [CELL_W-1:0]    val_q, val_d;
    logic                 spawn_ok_q, spawn_ok_d;
    logic [CELL_W-1:0]    cur_cell;
    logic                 finish;
    logic                 placed;
`ifdef TILE_SPAWN_DUAL_START_EN
    logic                 first_q, first_d;
    logic                 second_q, second_d;
`endif

    assign cur_cell = board_q[idx_q*CELL_W +: CELL_W];

    // Next-state logic: accept in IDLE, probe one cell per clock in SEARCH, report in DONE.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        board_d     = board_q;
        board_out_d = board_out_q;
        idx_d       = idx_q;
        probes_d    = probes_q;
        spawn_idx_d = spawn_idx_q;
        val_d       = val_q;
        spawn_ok_d  = spawn_ok_q;
        finish      = 1'b0;
        placed      = 1'b0;
`ifdef TILE_SPAWN_DUAL_START_EN
        first_d     = first_q;
        second_d    = second_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (spawn_req_i) begin
                    board_d  = board_in_i;
                    idx_d    = rand_i;
                    probes_d = '0;
                    val_d    = two_or_four_i ? CELL_W'(1) : CELL_W'(2);
                    state_d  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cur_cell == '0) begin
                    board_d[idx_q*CELL_W +: CELL_W] = val_q;
`ifdef TILE_SPAWN_DUAL_START_EN
                    if (first_q && !second_q) begin
                        state_d = S_RESTART;
                    end else begin
                        finish = 1'b1;
                        placed = 1'b1;
                    end
`else
                    finish = 1'b1;
                    placed = 1'b1;
`endif
                end else if (probes_q == 4'd15) begin
                    finish = 1'b1;
                end else begin
                    idx_d    = idx_q + 4'd1;
                    probes_d = probes_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef TILE_SPAWN_DUAL_START_EN
            S_RESTART: begin
                // Second placement of the opening: fresh start cell and value on the updated board.
                idx_d    = rand_i;
                probes_d = '0;
                val_d    = two_or_four_i ? CELL_W'(1) : CELL_W'(2);
                second_d = 1'b1;
                state_d  = S_SEARCH;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d     = S_DONE;
            spawn_ok_d  = placed;
            board_out_d = board_d;
            if (placed) begin
                spawn_idx_d = idx_q;
            end
`ifdef TILE_SPAWN_DUAL_START_EN
            first_d  = 1'b0;
            second_d = 1'b0;
`endif
        end
    end

    // State and datapath registers; reset clears everything, so no partial board survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            // NOTE: the latched board is a plain register, not a RAM, so resetting it is cheap and keeps outputs deterministic.
            board_q     <= '0;
            board_out_q <= '0;
            idx_q       <= '0;
            probes_q    <= '0;
            spawn_idx_q <= '0;
            val_q       <= '0;
            spawn_ok_q  <= 1'b0;
`ifdef TILE_SPAWN_DUAL_START_EN
            first_q     <= 1'b1;
            second_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            state_q     <= state_d;
            board_q     <= board_d;
            board_out_q <= board_out_d;
            idx_q       <= idx_d;
            probes_q    <= probes_d;
            spawn_idx_q <= spawn_idx_d;
            val_q       <= val_d;
            spawn_ok_q  <= spawn_ok_d;
`ifdef TILE_SPAWN_DUAL_START_EN
            first_q     <= first_d;
            second_q    <= second_d;
`endif
        end
    end

    assign board_out_o  = board_out_q;
    assign spawn_ok_o   = spawn_ok_q;
    assign spawn_idx_o  = spawn_idx_q;
    assign spawn_done_o = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tile_spawner.sv
// Testbench for tile_spawner: hand-computed vector table, multi-cycle corner sequences,
// and randomized boards checked against a simple probe-order reference model.
module tb_tile_spawner;

    localparam int CELL_W  = 4;
    localparam int N_CELLS = 16;
    localparam int BW      = CELL_W * N_CELLS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          spawn_req = 1'b0;
    logic [BW-1:0] board_in = '0;
    logic [3:0]    rnd = '0;
    logic          two_or_four = 1'b0;
    logic [BW-1:0] board_out;
    logic          spawn_done;
    logic          spawn_ok;
    logic [3:0]    spawn_idx;
    logic          busy;

    int checks = 0;
    int errors = 0;

    tile_spawner #(.CELL_W(CELL_W), .N_CELLS(N_CELLS)) dut (
        .clk          (clk),
        .rst          (rst),
        .spawn_req_i  (spawn_req),
        .board_in_i   (board_in),
        .rand_i       (rnd),
        .two_or_four_i(two_or_four),
        .board_out_o  (board_out),
        .spawn_done_o (spawn_done),
        .spawn_ok_o   (spawn_ok),
        .spawn_idx_o  (spawn_idx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: scan cells start, start+1, ... mod 16; the first empty one takes the tile.
    // p is the number of probes, i.e. the edge after acceptance at which the search ends.
    function automatic void model(input logic [BW-1:0] b, input logic [3:0] start, input bit tof,
                                  output bit ok, output logic [3:0] idx,
                                  output logic [BW-1:0] nb, output int p);
        nb  = b;
        ok  = 1'b0;
        idx = '0;
        p   = 16;
        for (int k = 0; k < 16; k++) begin
            int c;
            c = (int'(start) + k) % 16;
            if (b[c*CELL_W +: CELL_W] == '0) begin
                nb[c*CELL_W +: CELL_W] = tof ? 4'd1 : 4'd2;
                ok  = 1'b1;
                idx = c[3:0];
                p   = k + 1;
                break;
            end
        end
    endfunction

    // Issue one request and wait (bounded) for spawn_done.
    // lat counts edges after the accepting edge.
    task automatic run_spawn(input logic [BW-1:0] b, input logic [3:0] r, input bit tof,
                             input bit disturb, input bit req_at_done,
                             output bit ok, output logic [3:0] idx,
                             output logic [BW-1:0] bo, output int lat);
        bit busy_bad;
        bit idle_bad;
        @(negedge clk);
        board_in    = b;
        rnd         = r;
        two_or_four = tof;
        spawn_req   = 1'b1;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        busy_bad = 1'b0;
        lat = 0;
        while (!spawn_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busy_bad = 1'b1;
            if (disturb && lat == 1) begin
                spawn_req = 1'b1;
                rnd       = ~r;
                board_in  = '0;
                two_or_four = ~tof;
            end
            if (disturb && lat == 2) spawn_req = 1'b0;
        end
        check("done_within_budget", 64'(lat < 40), 64'd1);
        check("busy_held_while_searching", 64'(busy_bad), 64'd0);
        ok  = spawn_ok;
        idx = spawn_idx;
        bo  = board_out;
        if (req_at_done) spawn_req = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            spawn_req = 1'b0;
            if (spawn_done || busy || board_out !== bo) idle_bad = 1'b1;
        end
        check("idle_and_hold_after_done", 64'(idle_bad), 64'd0);
    endtask

    typedef struct {
        logic [BW-1:0] board;
        logic [3:0]    r;
        bit            tof;
        bit            ok;
        logic [3:0]    idx;
        logic [BW-1:0] exp_board;
        int            lat;
    } vec_t;

    vec_t vecs[4];

`ifdef TILE_SPAWN_DUAL_START_EN
    // Opening position: empty board, start cell 3 both times gives cells 3 and 4.
    // Latency is 1 probe, the re-sample edge, then 2 probes.
    task automatic dual_start_test();
        bit ok;
        logic [3:0] idx;
        logic [BW-1:0] bo;
        int lat;
        run_spawn('0, 4'd3, 1'b1, 1'b0, 1'b0, ok, idx, bo, lat);
        check("dual_ok", 64'(ok), 64'd1);
        check("dual_idx", 64'(idx), 64'd4);
        check("dual_board", bo, 64'h0000_0000_0001_1000);
        check("dual_lat", 64'(lat), 64'd4);
        run_spawn('0, 4'd3, 1'b1, 1'b0, 1'b0, ok, idx, bo, lat);
        check("after_dual_single_board", bo, 64'h0000_0000_0000_1000);
        check("after_dual_single_lat", 64'(lat), 64'd1);
    endtask
`endif

    initial begin
        bit            ok;
        bit            m_ok;
        logic [3:0]    idx;
        logic [3:0]    m_idx;
        logic [BW-1:0] bo;
        logic [BW-1:0] m_b;
        logic [BW-1:0] rb;
        int            lat;
        int            m_p;

        vecs[0] = '{board: '0, r: 4'd5, tof: 1'b1, ok: 1'b1, idx: 4'd5,
                    exp_board: 64'h0000_0000_0010_0000, lat: 1};
        vecs[1] = '{board: 64'h3300_0000_0000_0003, r: 4'd14, tof: 1'b0, ok: 1'b1, idx: 4'd1,
                    exp_board: 64'h3300_0000_0000_0023, lat: 4};
        vecs[2] = '{board: 64'h1234_5678_9ABC_DEF1, r: 4'd9, tof: 1'b1, ok: 1'b0, idx: 4'd0,
                    exp_board: 64'h1234_5678_9ABC_DEF1, lat: 16};
        vecs[3] = '{board: 64'h5000_0000_0000_0000, r: 4'd15, tof: 1'b1, ok: 1'b1, idx: 4'd0,
                    exp_board: 64'h5000_0000_0000_0001, lat: 2};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_board_out", board_out, 64'd0);
        check("rst_done", 64'(spawn_done), 64'd0);
        check("rst_ok", 64'(spawn_ok), 64'd0);
        check("rst_idx", 64'(spawn_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef TILE_SPAWN_DUAL_START_EN
        dual_start_test();
`endif

        // Table-driven vectors.
        for (int i = 0; i < 4; i++) begin
            run_spawn(vecs[i].board, vecs[i].r, vecs[i].tof, 1'b0, 1'b0, ok, idx, bo, lat);
            check($sformatf("vec%0d_ok", i), 64'(ok), 64'(vecs[i].ok));
            if (vecs[i].ok) check($sformatf("vec%0d_idx", i), 64'(idx), 64'(vecs[i].idx));
            check($sformatf("vec%0d_board", i), bo, vecs[i].exp_board);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Re-pulsed request and changed inputs mid-search: result follows the first request.
        run_spawn(vecs[1].board, vecs[1].r, vecs[1].tof, 1'b1, 1'b0, ok, idx, bo, lat);
        check("disturb_ok", 64'(ok), 64'd1);
        check("disturb_idx", 64'(idx), 64'd1);
        check("disturb_board", bo, vecs[1].exp_board);
        check("disturb_lat", 64'(lat), 64'd4);

        // Request raised in the DONE cycle is dropped (checked by the idle check in run_spawn).
        run_spawn(vecs[0].board, 4'd7, 1'b0, 1'b0, 1'b1, ok, idx, bo, lat);
        check("req_at_done_idx", 64'(idx), 64'd7);

        // Randomized boards against the reference model.
        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < N_CELLS; c++) begin
                if (t % 7 != 3 && $urandom_range(0, 3) == 0) rb[c*CELL_W +: CELL_W] = '0;
                else rb[c*CELL_W +: CELL_W] = 4'($urandom_range(1, 11));
            end
            idx = 4'($urandom_range(0, 15));
            ok  = 1'($urandom_range(0, 1));
            model(rb, idx, ok, m_ok, m_idx, m_b, m_p);
            run_spawn(rb, idx, ok, 1'b0, 1'b0, ok, idx, bo, lat);
            check($sformatf("rnd%0d_ok", t), 64'(ok), 64'(m_ok));
            if (m_ok) check($sformatf("rnd%0d_idx", t), 64'(idx), 64'(m_idx));
            check($sformatf("rnd%0d_board", t), bo, m_b);
            check($sformatf("rnd%0d_lat", t), 64'(lat), 64'(m_p));
        end

        // Asynchronous reset in the middle of a full-board search.
        @(negedge clk);
        board_in  = vecs[2].board;
        rnd       = 4'd2;
        spawn_req = 1'b1;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_board_out", board_out, 64'd0);
        check("midrst_done", 64'(spawn_done), 64'd0);
        check("midrst_ok", 64'(spawn_ok), 64'd0);
        check("midrst_idx", 64'(spawn_idx), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef TILE_SPAWN_DUAL_START_EN
        dual_start_test();
`else
        run_spawn(vecs[0].board, vecs[0].r, vecs[0].tof, 1'b0, 1'b0, ok, idx, bo, lat);
        check("post_rst_ok", 64'(ok), 64'd1);
        check("post_rst_idx", 64'(idx), 64'd5);
        check("post_rst_board", bo, vecs[0].exp_board);
        check("post_rst_lat", 64'(lat), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
